// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake direction controller.
// Directions are 5-bit one-hot; bit 0 is never used so an all-zero code is recognisably invalid.
package snake_pkg;

    localparam int DEBOUNCE_DEFAULT = 250000;

    localparam logic [4:0] DIR_UP    = 5'b00010;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;
    localparam logic [4:0] DIR_DOWN  = 5'b01000;
    localparam logic [4:0] DIR_RIGHT = 5'b10000;

    function automatic logic [4:0] dir_opposite(input logic [4:0] d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] dir_clockwise(input logic [4:0] d);
        case (d)
            DIR_UP:    return DIR_RIGHT;
            DIR_RIGHT: return DIR_DOWN;
            DIR_DOWN:  return DIR_LEFT;
            DIR_LEFT:  return DIR_UP;
            default:   return 5'b00000;
        endcase
    endfunction

    function automatic logic dir_valid(input logic [4:0] d);
        return (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_RIGHT);
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button input: 2-FF synchroniser, stable-count debouncer and registered
// rising-edge press pulse (press appears 2 + DEBOUNCE_CYCLES + 1 cycles after the raw edge).
module btn_conditioner
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic master_clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic             level_d;

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b00;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction input stage: conditions the buttons, validates turns, queues them and
// commits one per update_tick. Optional clockwise button enabled by SNAKE_DIR_CYCLE_EN.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int          QDEPTH          = 2,
    parameter logic [4:0]  INIT_DIR        = DIR_UP,
    localparam int         QW              = $clog2(QDEPTH + 1)
) (
    input  logic          master_clk,
    input  logic          reset,
    input  logic          start,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
`ifdef SNAKE_DIR_CYCLE_EN
    input  logic          btn_cycle,
`endif
    input  logic          update_tick,
    output logic [4:0]    direction,
    output logic          turn_taken,
    output logic          turn_dropped,
    output logic [QW-1:0] queue_count
);

`ifdef SNAKE_DIR_CYCLE_EN
    localparam int NBTN = 5;
`else
    localparam int NBTN = 4;
`endif

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_level_unused;

`ifdef SNAKE_DIR_CYCLE_EN
    assign btn_raw = {btn_cycle, btn_left, btn_down, btn_right, btn_up};
`else
    assign btn_raw = {btn_left, btn_down, btn_right, btn_up};
`endif

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .master_clk (master_clk),
            .reset      (reset),
            .raw        (btn_raw[gi]),
            .level      (btn_level_unused[gi]),
            .press      (btn_press[gi])
        );
    end

    logic [4:0]    q      [QDEPTH];
    logic [4:0]    q_next [QDEPTH];
    logic [4:0]    ref_dir;
    logic [4:0]    req_dir;
    logic          req_valid;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [QW-1:0] count_next;
    int            tail;

    always_comb begin
        // Newest queued turn is the reference so that queued turns chain legally.
        ref_dir = direction;
        for (int i = 0; i < QDEPTH; i++) begin
            if (int'(queue_count) == i + 1) ref_dir = q[i];
        end

        req_dir = 5'b00000;
        if (btn_press[0])      req_dir = DIR_UP;
        else if (btn_press[1]) req_dir = DIR_RIGHT;
        else if (btn_press[2]) req_dir = DIR_DOWN;
        else if (btn_press[3]) req_dir = DIR_LEFT;
`ifdef SNAKE_DIR_CYCLE_EN
        else if (btn_press[4]) req_dir = dir_clockwise(ref_dir);
`endif

        req_valid = (req_dir != 5'b00000) && (req_dir != ref_dir) &&
                    (req_dir != dir_opposite(ref_dir));
        full = (queue_count == QW'(QDEPTH));
        pop  = update_tick && (queue_count != '0);
        push = req_valid && (!full || pop);
        drop = req_valid && full && !pop;

        q_next = q;
        if (pop) begin
            for (int i = 0; i < QDEPTH; i++) q_next[i] = q[(i + 1) % QDEPTH];
        end
        tail = int'(queue_count) - int'(pop);
        if (push) begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (i == tail) q_next[i] = req_dir;
            end
        end

        case ({push, pop})
            2'b10:   count_next = queue_count + QW'(1);
            2'b01:   count_next = queue_count - QW'(1);
            default: count_next = queue_count;
        endcase
    end

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            direction    <= INIT_DIR;
            queue_count  <= '0;
            turn_taken   <= 1'b0;
            turn_dropped <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) q[i] <= 5'b00000;
        end else if (!start) begin
            direction    <= INIT_DIR;
            queue_count  <= '0;
            turn_taken   <= 1'b0;
            turn_dropped <= 1'b0;
        end else begin
            q            <= q_next;
            queue_count  <= count_next;
            turn_taken   <= pop;
            turn_dropped <= drop;
            if (pop) direction <= dir_valid(q[0]) ? q[0] : INIT_DIR;
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl: directed scenarios plus randomized presses/ticks
// compared against a turn-level reference model (queue of direction indices).
module tb_snake_dir_ctrl;

    localparam int DEB = 4;
    localparam int QD  = 2;
    // Index order: 0 up, 1 right, 2 down, 3 left (clockwise, also press priority order)
    localparam logic [4:0] DIRS [4] = '{5'b00010, 5'b10000, 5'b01000, 5'b00100};

    logic       master_clk;
    logic       reset;
    logic       start;
    logic [3:0] btn_raw;
    logic       update_tick;
    logic [4:0] direction;
    logic       turn_taken;
    logic       turn_dropped;
    logic [1:0] queue_count;

    snake_dir_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .QDEPTH(QD)
    ) dut (
        .master_clk   (master_clk),
        .reset        (reset),
        .start        (start),
        .btn_up       (btn_raw[0]),
        .btn_down     (btn_raw[2]),
        .btn_left     (btn_raw[3]),
        .btn_right    (btn_raw[1]),
`ifdef SNAKE_DIR_CYCLE_EN
        .btn_cycle    (1'b0),
`endif
        .update_tick  (update_tick),
        .direction    (direction),
        .turn_taken   (turn_taken),
        .turn_dropped (turn_dropped),
        .queue_count  (queue_count)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int taken_seen = 0;
    int drop_seen = 0;

    // Reference model state
    logic [3:0] due [int];
    int         mq[$];
    int         mdir = 0;
    bit         mtaken = 0;
    bit         mdrop = 0;

    // A clean rising edge driven after edge N is consumed by the controller at edge N+8.
    task automatic set_btn(input int idx, input logic v);
        if (v && !btn_raw[idx]) begin
            if (due.exists(cyc + 2 + DEB + 2)) due[cyc + 2 + DEB + 2] |= (4'b0001 << idx);
            else due[cyc + 2 + DEB + 2] = (4'b0001 << idx);
        end
        btn_raw[idx] = v;
    endtask

    task automatic model_reset();
        mq.delete();
        mdir = 0;
        mtaken = 0;
        mdrop = 0;
        due.delete();
    endtask

    task automatic step(input bit tick);
        logic [3:0] m;
        int r, refi;
        bit valid, pop, full;
        update_tick = tick;
        @(posedge master_clk);
        cyc++;
        m = due.exists(cyc) ? due[cyc] : 4'b0000;
        if (!start) begin
            mq.delete();
            mdir = 0;
            mtaken = 0;
            mdrop = 0;
        end else begin
            r = -1;
            for (int i = 0; i < 4; i++) if (m[i] && r < 0) r = i;
            refi  = (mq.size() > 0) ? mq[$] : mdir;
            valid = (r >= 0) && (r != refi) && (r != (refi + 2) % 4);
            pop   = tick && (mq.size() > 0);
            full  = (mq.size() == QD);
            mtaken = pop;
            mdrop  = valid && full && !pop;
            if (pop) mdir = mq.pop_front();
            if (valid && (!full || pop)) mq.push_back(r);
        end
        #1;
        update_tick = 1'b0;
        if (turn_taken) taken_seen++;
        if (turn_dropped) drop_seen++;
    endtask

    task automatic restart();
        start = 1'b0;
        step(0);
        start = 1'b1;
        step(0);
    endtask

    task automatic tap(input int idx);
        set_btn(idx, 1'b1);
        repeat (8) step(0);
        set_btn(idx, 1'b0);
        repeat (8) step(0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        btn_raw = 4'b0000;
        update_tick = 1'b0;
        repeat (3) @(posedge master_clk);
        #1;
        tests++; if (direction !== 5'b00010) begin fails++; $display("FAIL reset_dir: got %b want 00010", direction); end
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", queue_count); end
        tests++; if (turn_taken !== 1'b0) begin fails++; $display("FAIL reset_taken: got %b want 0", turn_taken); end
        tests++; if (turn_dropped !== 1'b0) begin fails++; $display("FAIL reset_dropped: got %b want 0", turn_dropped); end
        reset = 1'b0;
        model_reset();
        restart();
    endtask

    task automatic test_turn_right();
        int t0;
        restart();
        set_btn(1, 1'b1);
        repeat (7) step(0);
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL right_early: count %0d want 0", queue_count); end
        step(0);
        tests++; if (queue_count !== 2'd1) begin fails++; $display("FAIL right_queued: count %0d want 1", queue_count); end
        set_btn(1, 1'b0);
        repeat (8) step(0);
        t0 = taken_seen;
        tests++; if (direction !== 5'b00010) begin fails++; $display("FAIL right_pre_tick: dir %b want 00010", direction); end
        step(1);
        tests++; if (direction !== 5'b10000) begin fails++; $display("FAIL right_dir: dir %b want 10000", direction); end
        tests++; if (turn_taken !== 1'b1) begin fails++; $display("FAIL right_taken: got %b want 1", turn_taken); end
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL right_drain: count %0d want 0", queue_count); end
        step(0);
        tests++; if (turn_taken !== 1'b0 || taken_seen - t0 != 1) begin
            fails++; $display("FAIL right_pulse_once: taken %b pulses %0d want 0/1", turn_taken, taken_seen - t0);
        end
    endtask

    task automatic test_reject_reverse();
        int t0, d0;
        restart();
        t0 = taken_seen;
        d0 = drop_seen;
        tap(2);
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL reverse_count: count %0d want 0", queue_count); end
        step(1);
        tests++; if (direction !== 5'b00010) begin fails++; $display("FAIL reverse_dir: dir %b want 00010", direction); end
        tests++; if (taken_seen != t0 || drop_seen != d0) begin
            fails++; $display("FAIL reverse_pulses: taken %0d dropped %0d want 0/0", taken_seen - t0, drop_seen - d0);
        end
        // Same direction as current is also rejected
        tap(0);
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL same_dir_count: count %0d want 0", queue_count); end
    endtask

    task automatic test_bounce();
        restart();
        for (int k = 0; k < 10; k++) begin
            btn_raw[3] = ~btn_raw[3];
            repeat (2) step(0);
        end
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL bounce_early: count %0d want 0", queue_count); end
        set_btn(3, 1'b1);
        repeat (8) step(0);
        tests++; if (queue_count !== 2'd1) begin fails++; $display("FAIL bounce_press: count %0d want 1", queue_count); end
        set_btn(3, 1'b0);
        repeat (8) step(0);
        tests++; if (queue_count !== 2'd1) begin fails++; $display("FAIL bounce_once: count %0d want 1", queue_count); end
        step(1);
        tests++; if (direction !== 5'b00100) begin fails++; $display("FAIL bounce_dir: dir %b want 00100", direction); end
    endtask

    task automatic test_queue_full();
        int d0;
        restart();
        d0 = drop_seen;
        tap(1);
        tap(2);
        tap(3);
        tests++; if (queue_count !== 2'd2) begin fails++; $display("FAIL full_count: count %0d want 2", queue_count); end
        tests++; if (drop_seen - d0 != 1) begin fails++; $display("FAIL full_drop: drops %0d want 1", drop_seen - d0); end
        step(1);
        tests++; if (direction !== 5'b10000) begin fails++; $display("FAIL full_tick1: dir %b want 10000", direction); end
        step(1);
        tests++; if (direction !== 5'b01000) begin fails++; $display("FAIL full_tick2: dir %b want 01000", direction); end
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL full_drain: count %0d want 0", queue_count); end
    endtask

    task automatic test_simultaneous();
        restart();
        tap(3);
        step(1);
        tests++; if (direction !== 5'b00100) begin fails++; $display("FAIL simul_setup: dir %b want 00100", direction); end
        // right outranks down, and right is then rejected as a reversal: nothing queued
        set_btn(1, 1'b1); set_btn(2, 1'b1);
        repeat (8) step(0);
        set_btn(1, 1'b0); set_btn(2, 1'b0);
        repeat (8) step(0);
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL simul_rd: count %0d want 0", queue_count); end
        set_btn(0, 1'b1); set_btn(1, 1'b1);
        repeat (8) step(0);
        set_btn(0, 1'b0); set_btn(1, 1'b0);
        repeat (8) step(0);
        tests++; if (queue_count !== 2'd1) begin fails++; $display("FAIL simul_ur_count: count %0d want 1", queue_count); end
        step(1);
        tests++; if (direction !== 5'b00010) begin fails++; $display("FAIL simul_ur_dir: dir %b want 00010", direction); end
    endtask

    task automatic test_start_low();
        int t0;
        restart();
        tap(1);
        tests++; if (queue_count !== 2'd1) begin fails++; $display("FAIL flush_setup: count %0d want 1", queue_count); end
        start = 1'b0;
        step(0);
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL flush_count: count %0d want 0", queue_count); end
        tests++; if (direction !== 5'b00010) begin fails++; $display("FAIL flush_dir: dir %b want 00010", direction); end
        t0 = taken_seen;
        repeat (3) step(1);
        tests++; if (direction !== 5'b00010 || taken_seen != t0) begin
            fails++; $display("FAIL idle_ticks: dir %b pulses %0d want 00010/0", direction, taken_seen - t0);
        end
        set_btn(2, 1'b1);
        repeat (10) step(0);
        start = 1'b1;
        repeat (6) step(0);
        set_btn(2, 1'b0);
        repeat (8) step(0);
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL held_through_start: count %0d want 0", queue_count); end
    endtask

    task automatic test_reset_mid();
        int t0, d0;
        restart();
        tap(1);
        set_btn(3, 1'b1);
        repeat (3) step(0);
        #2 reset = 1'b1;
        #1;
        tests++; if (direction !== 5'b00010) begin fails++; $display("FAIL midrst_dir: dir %b want 00010", direction); end
        tests++; if (queue_count !== 2'd0) begin fails++; $display("FAIL midrst_count: count %0d want 0", queue_count); end
        tests++; if (turn_taken !== 1'b0 || turn_dropped !== 1'b0) begin
            fails++; $display("FAIL midrst_pulses: taken %b dropped %b want 0/0", turn_taken, turn_dropped);
        end
        btn_raw = 4'b0000;
        model_reset();
        repeat (2) @(posedge master_clk);
        #1 reset = 1'b0;
        t0 = taken_seen;
        d0 = drop_seen;
        repeat (14) step(0);
        step(1);
        tests++; if (queue_count !== 2'd0 || direction !== 5'b00010) begin
            fails++; $display("FAIL midrst_spurious: count %0d dir %b want 0/00010", queue_count, direction);
        end
        tests++; if (taken_seen != t0 || drop_seen != d0) begin
            fails++; $display("FAIL midrst_after_pulses: taken %0d dropped %0d want 0/0", taken_seen - t0, drop_seen - d0);
        end
    endtask

    task automatic test_random();
        int action, a, b;
        bit two;
        restart();
        for (int it = 0; it < 60; it++) begin
            action = $urandom_range(0, 9);
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            two = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 15; c++) begin
                if (action == 0) begin
                    start = (c >= 2);
                end else if (c == 0) begin
                    set_btn(a, 1'b1);
                    if (two) set_btn(b, 1'b1);
                end else if (c == 7) begin
                    set_btn(a, 1'b0);
                    set_btn(b, 1'b0);
                end
                step($urandom_range(0, 5) == 0);
                tests++; if (direction !== DIRS[mdir]) begin
                    fails++; $display("FAIL rand_dir it%0d c%0d: dir %b want %b", it, c, direction, DIRS[mdir]);
                end
                tests++; if (int'(queue_count) != mq.size()) begin
                    fails++; $display("FAIL rand_count it%0d c%0d: count %0d want %0d", it, c, queue_count, mq.size());
                end
                tests++; if (turn_taken !== mtaken) begin
                    fails++; $display("FAIL rand_taken it%0d c%0d: got %b want %b", it, c, turn_taken, mtaken);
                end
                tests++; if (turn_dropped !== mdrop) begin
                    fails++; $display("FAIL rand_dropped it%0d c%0d: got %b want %b", it, c, turn_dropped, mdrop);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_turn_right();
        test_reject_reverse();
        test_bounce();
        test_queue_full();
        test_simultaneous();
        test_start_low();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded 1 ms");
        $fatal(1);
    end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Upstream input stage for the snake game core. Conditions four raw direction push-buttons: synchronise, debounce and edge-detect each one.
- Rejects illegal turns (same direction or 180° reversal) and buffers legal turns in a small FIFO.
- Commits one queued turn per movement tick, so that fast double-taps between ticks are not lost.
- Drives the one-hot direction bus consumed by the snake position-update logic.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable master_clk cycles before a button level is accepted (5 ms at 50 MHz); minimum 2.
- QDEPTH, 2, turn-queue depth in entries; minimum 1.
- INIT_DIR, 5'b00010, direction after reset and while start is low (up).

Ports:
- master_clk, in, 1, 50 MHz system clock.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, game-run switch; low = idle/flush.
- btn_up / btn_down / btn_left / btn_right, in, 1 each, raw asynchronous buttons, active-high.
- update_tick, in, 1, one-cycle pulse in the master_clk domain marking each snake step.
- direction, out, 5, one-hot: 00010 up, 00100 left, 01000 down, 10000 right.
- turn_taken, out, 1, one-cycle pulse when direction changes on a tick.
- turn_dropped, out, 1, one-cycle pulse when a valid press is lost because the queue is full.
- queue_count, out, $clog2(QDEPTH+1), number of pending turns.

Behaviour:
- Reset (async, active-high):
  - direction = INIT_DIR; queue empty; queue_count = 0.
  - turn_taken = 0; turn_dropped = 0.
  - Synchroniser flops, debounced levels and debounce counters all 0.
- Per button, in order:
  - 2-FF synchroniser.
  - Debounce counter: resets to 0 whenever the synced level equals the debounced level. Otherwise it increments; on reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a one-cycle press pulse.
  - Press pulse latency from the raw edge: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Simultaneous press pulses in one cycle: a single request is chosen with priority up > right > down > left; the rest are discarded silently.
- Reference direction: the newest queued entry if queue_count > 0 (pre-pop), else the current direction register.
- Request validation: a request equal to the reference or opposite to it is rejected silently. Rejection produces no pulse and no queue change.
- Valid request:
  - Queue not full: pushed at the tail.
  - Queue full and no pop this cycle: dropped and turn_dropped pulses.
  - Queue full with a pop this cycle: accepted.
- update_tick with queue non-empty:
  - Head popped into direction; turn_taken pulses on the same edge.
  - Registered output, so the new direction is visible 1 cycle after the tick.
- update_tick with queue empty: direction is held; no pulse.
- Same-cycle push and pop: both happen; queue_count is unchanged; validation uses the pre-pop reference.
- No bypass: a press accepted in the same cycle as a tick on an empty queue is applied at the next tick.
- start low:
  - Queue flushed; direction forced to INIT_DIR; presses ignored; update_tick ignored; no pulses.
  - Debouncers keep running, so a button held through start's rising edge does not generate a press.
- start rising: normal operation begins the next cycle.
- direction is always exactly one-hot; an invalid internal code is never output.

Optional Feature:
- Macro SNAKE_DIR_CYCLE_EN.
- Defined:
  - Adds input btn_cycle (1 bit, raw), conditioned identically to the other buttons.
  - Its press requests the clockwise successor of the reference direction: up→right→down→left→up.
  - Lowest priority, below left.
  - Subject to the same validation and queueing rules.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package snake_pkg:
  - Constants DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT (5-bit one-hot).
  - Functions dir_opposite() and dir_clockwise().
  - The default DEBOUNCE_CYCLES value.
- Sub-module btn_conditioner:
  - Contents: synchroniser, debouncer and rising-edge detector.
  - Parameter DEBOUNCE_CYCLES.
  - Ports master_clk, reset, raw, level, press.
  - Instantiated 4 times (5 with SNAKE_DIR_CYCLE_EN).
- Priority select, validation, FIFO and output register stay in snake_dir_ctrl.

Test Plan:
- Bench uses DEBOUNCE_CYCLES = 4.
- Reset, start = 1, press btn_right, then tick → direction goes 00010→10000 one cycle after the tick; turn_taken pulses once; queue_count 1→0.
- direction = up, press down, then tick → request rejected; direction stays 00010; queue_count stays 0; no turn_taken and no turn_dropped.
- Bounce test: btn_left toggles every 2 cycles for 20 cycles, then holds high → exactly one press; after a tick direction = 00100.
- QDEPTH = 2, direction = up:
  - Press right, then down, then left before any tick → third press drops with turn_dropped pulse; queue_count = 2.
  - Two ticks → direction goes 10000, then 01000.
- btn_up and btn_right pulse in the same cycle while direction = left → up wins; queue holds 00010 only.
- Queue holds 1 entry; start drops low → queue_count = 0 next cycle; direction = 00010.
- Ticks while start is low → no change.
- Assert reset mid-debounce and with the queue non-empty → all outputs at reset values immediately; no spurious press after release.
